// File: rtl/vram_arbiter_if.sv
// Arbiter-side bundle: VGA timing inputs, ROM port and the secondary valid/ready read port.
// slave = arbiter, master = the surrounding system (VGA driver, ROM, secondary requester).
interface vram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12
);
  logic [1:0]        pix_phase;
  logic [9:0]        row_addr;
  logic [9:0]        col_addr;
  logic [DATA_W-1:0] vga_data;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              sec_req;
  logic [ADDR_W-1:0] sec_addr;
  logic              sec_gnt;
  logic              sec_rvalid;
  logic [DATA_W-1:0] sec_rdata;

  modport slave (
    input  pix_phase, row_addr, col_addr, rom_data, sec_req, sec_addr,
    output vga_data, rom_en, rom_addr, sec_gnt, sec_rvalid, sec_rdata
  );

  modport master (
    output pix_phase, row_addr, col_addr, rom_data, sec_req, sec_addr,
    input  vga_data, rom_en, rom_addr, sec_gnt, sec_rvalid, sec_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Time-slot image-ROM arbiter: phase 0 belongs to VGA, every other slot to the secondary port.
// Read data returns ROM_LAT+1 edges after issue; sec_gnt is the only backpressure, sec_rvalid has none.
module vram_arbiter #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  vram_arbiter_if.slave  io_bus
);

  localparam int STAGES = ROM_LAT + 1;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_VGA   = 2'd1,
    TAG_BLANK = 2'd2,
    TAG_SEC   = 2'd3
  } tag_e;

  logic              w_visible;
  logic              w_phase0;
  logic              w_gnt;
  logic              w_sec_issue;
  logic              w_vga_issue;
  logic [ADDR_W-1:0] w_pix_addr;
  tag_e              w_tag_in;

  logic              r_rom_en;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [DATA_W-1:0] r_vga_data;
  logic              r_sec_rvalid;
  logic [DATA_W-1:0] r_sec_rdata;
  tag_e              r_tag [STAGES];
  logic [STAGES-1:0] r_tvld;

  assign w_visible   = (int'(io_bus.row_addr) < HEIGHT) && (int'(io_bus.col_addr) < WIDTH);
  assign w_phase0    = (io_bus.pix_phase == 2'd0);
  assign w_gnt       = !w_phase0 || !w_visible;
  assign w_sec_issue = io_bus.sec_req && w_gnt;
  assign w_vga_issue = w_phase0 && w_visible;
  assign w_pix_addr  = ADDR_W'(io_bus.row_addr) * ADDR_W'(WIDTH) + ADDR_W'(io_bus.col_addr);

  // A stolen blank slot is tagged SEC only, so vga_data keeps its previous value.
  always_comb begin
    w_tag_in = TAG_NONE;
    if (w_sec_issue) begin
      w_tag_in = TAG_SEC;
    end else if (w_phase0) begin
      w_tag_in = w_visible ? TAG_VGA : TAG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_en     <= 1'b0;
      r_rom_addr   <= '0;
      r_vga_data   <= '0;
      r_sec_rvalid <= 1'b0;
      r_sec_rdata  <= '0;
      r_tvld       <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_tag[i] <= TAG_NONE;
      end
    end else begin
      if (w_sec_issue) begin
        r_rom_en   <= 1'b1;
        r_rom_addr <= io_bus.sec_addr;
      end else if (w_vga_issue) begin
        r_rom_en   <= 1'b1;
        r_rom_addr <= w_pix_addr;
      end else begin
        r_rom_en   <= 1'b0;
      end

      r_tag[0]  <= w_tag_in;
      r_tvld[0] <= (w_tag_in != TAG_NONE);
      for (int i = 1; i < STAGES; i++) begin
        r_tag[i]  <= r_tag[i-1];
        r_tvld[i] <= r_tvld[i-1];
      end

      // The tag leaving the last stage lines up with rom_data for its read.
      r_sec_rvalid <= 1'b0;
      if (r_tvld[STAGES-1]) begin
        case (r_tag[STAGES-1])
          TAG_VGA:   r_vga_data <= io_bus.rom_data;
          TAG_BLANK: r_vga_data <= '0;
          TAG_SEC: begin
            r_sec_rdata  <= io_bus.rom_data;
            r_sec_rvalid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign io_bus.sec_gnt    = w_gnt;
  assign io_bus.rom_en     = r_rom_en;
  assign io_bus.rom_addr   = r_rom_addr;
  assign io_bus.vga_data   = r_vga_data;
  assign io_bus.sec_rvalid = r_sec_rvalid;
  assign io_bus.sec_rdata  = r_sec_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: ROM_LAT=1 and ROM_LAT=3 instances share one stimulus stream,
// each with its own ROM model and expected-result queues.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  pix_phase = 2'd0;
  logic [9:0]  row_addr = 10'd0;
  logic [9:0]  col_addr = 10'd0;
  logic        sec_req = 1'b0;
  logic [18:0] sec_addr = 19'd0;

  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_W(19), .DATA_W(12)) if1 ();
  vram_arbiter_if #(.ADDR_W(19), .DATA_W(12)) if3 ();

  assign if1.pix_phase = pix_phase;
  assign if1.row_addr  = row_addr;
  assign if1.col_addr  = col_addr;
  assign if1.sec_req   = sec_req;
  assign if1.sec_addr  = sec_addr;
  assign if3.pix_phase = pix_phase;
  assign if3.row_addr  = row_addr;
  assign if3.col_addr  = col_addr;
  assign if3.sec_req   = sec_req;
  assign if3.sec_addr  = sec_addr;

  vram_arbiter #(.ROM_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .io_bus(if1.slave));
  vram_arbiter #(.ROM_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .io_bus(if3.slave));

  function automatic logic [11:0] rom_f(input logic [18:0] a);
    logic [18:0] h;
    h = a ^ (a >> 7) ^ (a >> 13) ^ 19'h005a3;
    return h[11:0];
  endfunction

  // ROM models: output register only updates while enabled; LAT=3 adds two pipeline stages.
  logic [11:0] rom1_q = 12'd0;
  logic [11:0] rom3_q [3] = '{12'd0, 12'd0, 12'd0};
  always @(posedge clk) begin
    if (if1.rom_en) rom1_q <= rom_f(if1.rom_addr);
    if (if3.rom_en) rom3_q[0] <= rom_f(if3.rom_addr);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign if1.rom_data = rom1_q;
  assign if3.rom_data = rom3_q[2];

  logic [11:0] o_vga [2];
  logic [11:0] o_rdata [2];
  logic        o_rv [2];
  logic        o_gnt [2];
  assign o_vga[0]   = if1.vga_data;
  assign o_vga[1]   = if3.vga_data;
  assign o_rdata[0] = if1.sec_rdata;
  assign o_rdata[1] = if3.sec_rdata;
  assign o_rv[0]    = if1.sec_rvalid;
  assign o_rv[1]    = if3.sec_rvalid;
  assign o_gnt[0]   = if1.sec_gnt;
  assign o_gnt[1]   = if3.sec_gnt;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input int l, input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL [lat%0d] %s: got %0d, expected %0d", l, nm, act, exp);
    end
  endfunction

  typedef struct {
    logic [11:0] val;
    int          due;
  } sb_t;

  sb_t         q_sec [2][$];
  sb_t         q_vga [2][$];
  int          lat [2] = '{1, 3};
  logic [11:0] vexp [2] = '{12'd0, 12'd0};
  int          rv_cnt [2] = '{0, 0};
  int          cyc = 0;
  logic        mvis;
  logic        mgnt;
  sb_t         pe;
  sb_t         se;

  // Issue side: predict grant and push the expected result with its landing edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      mvis = (row_addr < 10'd480) && (col_addr < 10'd640);
      mgnt = (pix_phase != 2'd0) || !mvis;
      for (int d = 0; d < 2; d++) begin
        chk(lat[d], "sec_gnt", o_gnt[d], mgnt);
        if (sec_req && mgnt) begin
          pe.val = rom_f(sec_addr);
          pe.due = cyc + lat[d] + 1;
          q_sec[d].push_back(pe);
        end else if (pix_phase == 2'd0) begin
          pe.val = mvis ? rom_f(19'(row_addr * 640 + col_addr)) : 12'd0;
          pe.due = cyc + lat[d] + 1;
          q_vga[d].push_back(pe);
        end
      end
    end
  end

  // Return side: every sec_rvalid must match the queue head on its due edge; vga_data must hold otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (o_rv[d]) begin
          rv_cnt[d]++;
          if (q_sec[d].size() == 0) begin
            chk(lat[d], "sec_rvalid_unexpected", o_rv[d], 0);
          end else begin
            se = q_sec[d].pop_front();
            chk(lat[d], "sec_rvalid_edge", cyc, se.due);
            chk(lat[d], "sec_rdata", o_rdata[d], se.val);
          end
        end else if (q_sec[d].size() != 0 && q_sec[d][0].due <= cyc) begin
          se = q_sec[d].pop_front();
          chk(lat[d], "sec_rvalid_missing", o_rv[d], 1);
        end
        if (q_vga[d].size() != 0 && q_vga[d][0].due == cyc) begin
          se = q_vga[d].pop_front();
          vexp[d] = se.val;
        end
        chk(lat[d], "vga_data", o_vga[d], vexp[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pix_phase = pix_phase + 2'd1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(1, {tag, " vga_data"},   if1.vga_data,   0);
    chk(1, {tag, " rom_en"},     if1.rom_en,     0);
    chk(1, {tag, " rom_addr"},   if1.rom_addr,   0);
    chk(1, {tag, " sec_rvalid"}, if1.sec_rvalid, 0);
    chk(1, {tag, " sec_rdata"},  if1.sec_rdata,  0);
    chk(3, {tag, " vga_data"},   if3.vga_data,   0);
    chk(3, {tag, " rom_en"},     if3.rom_en,     0);
    chk(3, {tag, " rom_addr"},   if3.rom_addr,   0);
    chk(3, {tag, " sec_rvalid"}, if3.sec_rvalid, 0);
    chk(3, {tag, " sec_rdata"},  if3.sec_rdata,  0);
  endtask

  typedef struct {
    logic [1:0]  ph;
    logic [9:0]  row;
    logic [9:0]  col;
    logic        req;
    logic [18:0] addr;
    logic        e_gnt;
    logic        e_en;
    logic [18:0] e_addr;
  } vec_t;

  vec_t vt [10];
  int   base [2];

  initial begin
    vt[0] = '{2'd0, 10'd2,    10'd5,    1'b0, 19'd0,      1'b0, 1'b1, 19'd1285};
    vt[1] = '{2'd0, 10'd0,    10'd700,  1'b0, 19'd0,      1'b1, 1'b0, 19'd1285};
    vt[2] = '{2'd1, 10'd2,    10'd5,    1'b1, 19'd100,    1'b1, 1'b1, 19'd100};
    vt[3] = '{2'd0, 10'd2,    10'd5,    1'b1, 19'd100,    1'b0, 1'b1, 19'd1285};
    vt[4] = '{2'd0, 10'd0,    10'd650,  1'b1, 19'd307199, 1'b1, 1'b1, 19'd307199};
    vt[5] = '{2'd2, 10'd480,  10'd0,    1'b0, 19'd0,      1'b1, 1'b0, 19'd307199};
    vt[6] = '{2'd0, 10'd479,  10'd0,    1'b0, 19'd0,      1'b0, 1'b1, 19'd306560};
    vt[7] = '{2'd3, 10'd479,  10'd639,  1'b1, 19'd0,      1'b1, 1'b1, 19'd0};
    vt[8] = '{2'd0, 10'd1023, 10'd1023, 1'b0, 19'd0,      1'b1, 1'b0, 19'd0};
    vt[9] = '{2'd0, 10'd100,  10'd639,  1'b0, 19'd0,      1'b0, 1'b1, 19'd64639};

    #1 rst = 1'b1;
    #2 chk_reset_outputs("por");
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();

    for (int i = 0; i < 10; i++) begin
      while (pix_phase != vt[i].ph) tick();
      row_addr = vt[i].row;
      col_addr = vt[i].col;
      sec_req  = vt[i].req;
      sec_addr = vt[i].addr;
      #1 chk(1, $sformatf("vec%0d sec_gnt", i), if1.sec_gnt, vt[i].e_gnt);
      tick();
      sec_req = 1'b0;
      chk(1, $sformatf("vec%0d rom_en", i), if1.rom_en, vt[i].e_en);
      chk(1, $sformatf("vec%0d rom_addr", i), if1.rom_addr, vt[i].e_addr);
    end
    repeat (6) tick();

    // Slot sharing: a held request gets three of every four slots while visible.
    base = rv_cnt;
    while (pix_phase != 2'd1) tick();
    row_addr = 10'd2;
    col_addr = 10'd5;
    sec_req  = 1'b1;
    sec_addr = 19'd100;
    repeat (8) tick();
    sec_req = 1'b0;
    repeat (6) tick();
    chk(1, "share pulses", rv_cnt[0] - base[0], 6);
    chk(3, "share pulses", rv_cnt[1] - base[1], 6);

    // Reset with secondary reads in flight.
    while (pix_phase != 2'd1) tick();
    sec_req  = 1'b1;
    sec_addr = 19'd100;
    tick();
    tick();
    #2;
    rst     = 1'b1;
    sec_req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      q_sec[d].delete();
      q_vga[d].delete();
      vexp[d] = 12'd0;
    end
    base = rv_cnt;
    #1 chk_reset_outputs("midrst");
    tick();
    tick();
    rst = 1'b0;
    while (pix_phase != 2'd0) tick();
    tick();
    chk(1, "post-reset rom_en", if1.rom_en, 1);
    chk(1, "post-reset rom_addr", if1.rom_addr, 1285);
    chk(3, "post-reset rom_en", if3.rom_en, 1);
    chk(3, "post-reset rom_addr", if3.rom_addr, 1285);
    repeat (6) tick();
    chk(1, "post-reset sec pulses", rv_cnt[0] - base[0], 0);
    chk(3, "post-reset sec pulses", rv_cnt[1] - base[1], 0);

    // Full visible line at the last row.
    row_addr = 10'd479;
    for (int c = 0; c < 640; c++) begin
      while (pix_phase != 2'd0) tick();
      col_addr = 10'(c);
      tick();
    end
    repeat (8) tick();

    chk(1, "sec queue drained", q_sec[0].size(), 0);
    chk(3, "sec queue drained", q_sec[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
